countdown_timer: RTL and testbench

Loadable down-counter: the decrementing counterpart of the team's free-running up-counter. Software or an upstream FSM loads a terminal value over a valid/ready handshake and starts the block. It counts down to expiry, raises a sticky done flag that must be acknowledged, and can auto-reload for periodic operation. It sits beside the up-counter in the timing/sequencing layer and drives timeouts and periodic strobes.

---
 rtl/countdown_timer_if.sv | 12 +
 rtl/countdown_timer.sv | 104 ++++++++++
 tb/tb_countdown_timer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Load handshake between an upstream master (software/FSM) and the countdown timer.
// The master presents a terminal value; the timer accepts it when load_ready is high.
interface countdown_timer_if #(
    parameter int WIDTH = 6
);
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             load_ready;

    modport master (output load_valid, load_value, input load_ready);
    modport slave  (input load_valid, load_value, output load_ready);
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with sticky done flag, optional auto-reload and
// a wrapping expiry event counter.
module countdown_timer #(
    parameter int WIDTH = 6,
    parameter int EXP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    countdown_timer_if.slave  ld,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic              reload_en,
    input  logic              done_ack,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              expire,
    output logic [EXP_W-1:0]  expire_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] reload_reg;
    logic             load_fire;

    assign ld.load_ready = (state != S_RUN);
    assign load_fire     = ld.load_valid && ld.load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            reload_reg <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            expire     <= 1'b0;
            expire_cnt <= '0;
        end else begin
            expire <= 1'b0;
            if (abort) begin
                // reload_reg and expire_cnt survive an abort
                state <= S_IDLE;
                count <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                if (load_fire) begin
                    count      <= ld.load_value;
                    reload_reg <= ld.load_value;
                end
                case (state)
                    S_IDLE: begin
                        if (start && !load_fire) begin
                            if (count != '0) begin
                                state <= S_RUN;
                                busy  <= 1'b1;
                            end else begin
                                // zero terminal value expires immediately
                                state      <= S_DONE;
                                done       <= 1'b1;
                                expire     <= 1'b1;
                                expire_cnt <= expire_cnt + EXP_W'(1);
                            end
                        end
                    end
                    S_RUN: begin
                        if (!pause) begin
                            if (count > WIDTH'(1)) begin
                                count <= count - WIDTH'(1);
                            end else if (count == WIDTH'(1)) begin
                                expire     <= 1'b1;
                                expire_cnt <= expire_cnt + EXP_W'(1);
                                if (reload_en && reload_reg != '0) begin
                                    count <= reload_reg;
                                end else begin
                                    count <= '0;
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        if (done_ack) begin
                            state <= S_IDLE;
                            done  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized scenario bench for countdown_timer; expected counts are derived
// arithmetically from the number of unpaused edges since RUN entry.
module tb_countdown_timer;

    localparam int WIDTH = 6;
    localparam int EXP_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, pause, abort, reload_en, done_ack;
    logic [WIDTH-1:0] count;
    logic             busy, done, expire;
    logic [EXP_W-1:0] expire_cnt;

    int tests = 0;
    int fails = 0;
    int exp_total = 0;

    countdown_timer_if #(.WIDTH(WIDTH)) ld ();

    countdown_timer #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst), .ld(ld),
        .start(start), .pause(pause), .abort(abort), .reload_en(reload_en),
        .done_ack(done_ack), .count(count), .busy(busy), .done(done),
        .expire(expire), .expire_cnt(expire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v);
        ld.load_valid = 1'b1;
        ld.load_value = WIDTH'(v);
        tick();
        ld.load_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_total = 0;
        tests++;
        if (count !== 0 || busy !== 0 || done !== 0 || expire !== 0 ||
            expire_cnt !== 0 || ld.load_ready !== 1) begin
            fails++;
            $display("FAIL reset: count=%0d busy=%b done=%b expire=%b cnt=%0d rdy=%b (want 0,0,0,0,0,1)",
                     count, busy, done, expire, expire_cnt, ld.load_ready);
        end
    endtask

    // pmode: 0 no pause, 1 random pause, 2 pause on edges 2..4 after RUN entry
    task automatic test_oneshot(input int n, input int pmode);
        int u;
        int k;
        reload_en = 1'b0;
        load(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (count !== WIDTH'(n) || busy !== 1) begin
            fails++;
            $display("FAIL oneshot_entry: count=%0d busy=%b want %0d,1", count, busy, n);
        end
        u = 0;
        k = 0;
        while (u < n && k < 400) begin
            k++;
            pause = (pmode == 1) ? ($urandom_range(0, 3) == 0) :
                    (pmode == 2) ? (k >= 2 && k <= 4) : 1'b0;
            tick();
            if (!pause) u++;
            tests++;
            if (u < n) begin
                if (count !== WIDTH'(n - u) || busy !== 1 || expire !== 0 || done !== 0) begin
                    fails++;
                    $display("FAIL oneshot_run n=%0d edge=%0d: count=%0d busy=%b exp=%b done=%b want %0d,1,0,0",
                             n, k, count, busy, expire, done, n - u);
                end
            end else begin
                exp_total++;
                if (count !== 0 || expire !== 1 || done !== 1 || busy !== 0 ||
                    expire_cnt !== EXP_W'(exp_total)) begin
                    fails++;
                    $display("FAIL oneshot_expire n=%0d: count=%0d exp=%b done=%b busy=%b cnt=%0d want 0,1,1,0,%0d",
                             n, count, expire, done, busy, expire_cnt, exp_total % 256);
                end
            end
        end
        pause = 1'b0;
        if (u < n) begin
            tests++;
            fails++;
            $display("FAIL oneshot_timeout n=%0d: got %0d unpaused edges want %0d", n, u, n);
        end
        if (pmode == 2) begin
            tests++;
            if (k !== 7) begin
                fails++;
                $display("FAIL pause_latency: expire on edge %0d want 7", k);
            end
        end
        tick();
        tests++;
        if (expire !== 0 || done !== 1 || ld.load_ready !== 1) begin
            fails++;
            $display("FAIL done_sticky: exp=%b done=%b rdy=%b want 0,1,1", expire, done, ld.load_ready);
        end
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        tests++;
        if (done !== 0 || busy !== 0) begin
            fails++;
            $display("FAIL done_ack: done=%b busy=%b want 0,0", done, busy);
        end
    endtask

    task automatic test_reload(input int n, input int cycles, input bit rnd_pause);
        int u;
        bit exp_e;
        reload_en = 1'b1;
        load(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        u = 0;
        for (int k = 1; k <= cycles; k++) begin
            pause = rnd_pause ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            if (!pause) u++;
            exp_e = !pause && (u % n == 0);
            if (exp_e) exp_total++;
            tests++;
            if (count !== WIDTH'(n - (u % n)) || expire !== exp_e || done !== 0 ||
                busy !== 1 || expire_cnt !== EXP_W'(exp_total)) begin
                fails++;
                $display("FAIL reload n=%0d edge=%0d: count=%0d exp=%b done=%b busy=%b cnt=%0d want %0d,%b,0,1,%0d",
                         n, k, count, expire, done, busy, expire_cnt, n - (u % n), exp_e, exp_total % 256);
            end
        end
        pause = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        reload_en = 1'b0;
        tests++;
        if (count !== 0 || busy !== 0 || done !== 0 || expire !== 0) begin
            fails++;
            $display("FAIL reload_abort: count=%0d busy=%b done=%b exp=%b want 0,0,0,0",
                     count, busy, done, expire);
        end
    endtask

    task automatic test_zero_and_loads;
        load(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_total++;
        tests++;
        if (done !== 1 || expire !== 1 || count !== 0 || busy !== 0 ||
            expire_cnt !== EXP_W'(exp_total)) begin
            fails++;
            $display("FAIL zero_start: done=%b exp=%b count=%0d busy=%b cnt=%0d want 1,1,0,0,%0d",
                     done, expire, count, busy, expire_cnt, exp_total % 256);
        end
        load(7);
        tests++;
        if (count !== 7 || done !== 1 || expire !== 0) begin
            fails++;
            $display("FAIL load_in_done: count=%0d done=%b exp=%b want 7,1,0", count, done, expire);
        end
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        ld.load_valid = 1'b1;
        ld.load_value = WIDTH'(3);
        start = 1'b1;
        tick();
        ld.load_valid = 1'b0;
        start = 1'b0;
        tests++;
        if (count !== 3 || busy !== 0 || ld.load_ready !== 1) begin
            fails++;
            $display("FAIL load_with_start: count=%0d busy=%b rdy=%b want 3,0,1", count, busy, ld.load_ready);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        ld.load_valid = 1'b1;
        ld.load_value = WIDTH'(9);
        #1;
        tests++;
        if (ld.load_ready !== 0) begin
            fails++;
            $display("FAIL ready_in_run: rdy=%b want 0", ld.load_ready);
        end
        tick();
        tests++;
        if (count !== 2 || busy !== 1) begin
            fails++;
            $display("FAIL load_ignored_run: count=%0d busy=%b want 2,1", count, busy);
        end
        ld.load_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        load(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++;
        if (count !== 0 || busy !== 0 || done !== 0) begin
            fails++;
            $display("FAIL abort_idle: count=%0d busy=%b done=%b want 0,0,0", count, busy, done);
        end
    endtask

    task automatic test_abort_rst;
        load(6);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        tests++;
        if (count !== 2) begin
            fails++;
            $display("FAIL abort_setup: count=%0d want 2", count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++;
        if (count !== 0 || busy !== 0 || done !== 0 || expire !== 0 ||
            expire_cnt !== EXP_W'(exp_total)) begin
            fails++;
            $display("FAIL abort_run: count=%0d busy=%b done=%b exp=%b cnt=%0d want 0,0,0,0,%0d",
                     count, busy, done, expire, expire_cnt, exp_total % 256);
        end
        load(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_total = 0;
        tests++;
        if (count !== 0 || busy !== 0 || done !== 0 || expire !== 0 ||
            expire_cnt !== 0 || ld.load_ready !== 1) begin
            fails++;
            $display("FAIL rst_mid_run: count=%0d busy=%b done=%b exp=%b cnt=%0d rdy=%b want 0,0,0,0,0,1",
                     count, busy, done, expire, expire_cnt, ld.load_ready);
        end
    endtask

    task automatic test_wrap;
        // 260 back-to-back expiries from a fresh counter crosses 255 -> 0
        test_reload(1, 260, 1'b0);
        tests++;
        if (expire_cnt !== EXP_W'(260)) begin
            fails++;
            $display("FAIL wrap: cnt=%0d want %0d", expire_cnt, 260 % 256);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; pause = 1'b0; abort = 1'b0; reload_en = 1'b0; done_ack = 1'b0;
        ld.load_valid = 1'b0;
        ld.load_value = '0;
        test_reset();
        test_oneshot(5, 0);
        test_reload(3, 10, 1'b0);
        test_oneshot(4, 2);
        test_zero_and_loads();
        for (int i = 0; i < 6; i++) test_oneshot($urandom_range(1, 63), 1);
        for (int i = 0; i < 4; i++) test_reload($urandom_range(1, 9), 40, 1'b1);
        test_abort_rst();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
